l1_dcache: RTL
==============

Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Acts as the responder on the CPU data port (data_read/data_write/data_mbe/data_addr/data_wdata → data_resp/data_rdata), the port driven by the pipeline MEM stage.
- Misses are serviced over a 256-bit line-burst port to the L2/physical memory.
- Hits complete in the request cycle so the pipeline does not stall on hits.

Parameters:
- S_INDEX, 3, index bits; number of sets = 2**S_INDEX.
- S_OFFSET, 5, byte-offset bits; line = 256 bits, 8 words (fixed).
- S_TAG, 32-S_INDEX-S_OFFSET, tag bits (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- data_read  in  1  CPU load request, held until data_resp
- data_write  in  1  CPU store request, held until data_resp
- data_mbe  in  4  store byte enables
- data_addr  in  32  word-aligned address; [1:0] always 0
- data_wdata  in  32  store data, pre-shifted to byte lanes
- data_resp  out  1  request complete this cycle
- data_rdata  out  32  selected load word
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_address  out  32  line address; [4:0] = 0
- pmem_wdata  out  256  victim line
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  burst complete, one cycle

Behaviour:
- Address split: offset = addr[4:0], word = addr[4:2], index = addr[S_OFFSET+S_INDEX-1:S_OFFSET], tag = addr[31:S_OFFSET+S_INDEX].
- Arrays: valid[sets], dirty[sets], tag[sets], data[sets]x256. Reads are asynchronous; writes occur at posedge.
- Reset (async): state=IDLE; all valid and dirty bits = 0. Tag and data arrays are not reset. Outputs: data_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, data_rdata=0.
- FSM states: IDLE, WRITEBACK, FILL.
  - IDLE: hit = req && valid[index] && tag[index]==tag.
    - Read hit: data_resp=1 and data_rdata=data[index][word*32 +: 32], both combinational in the same cycle.
    - Write hit: data_resp=1 combinationally. At the edge, bytes with mbe[i]=1 of word `word` are merged from data_wdata; dirty[index] is set. With mbe=0000: resp=1, no data change, dirty unchanged.
    - Miss and dirty[index]: go to WRITEBACK.
    - Miss and clean: go to FILL.
    - data_resp=0 on every miss cycle.
  - WRITEBACK: pmem_write=1, pmem_address={tag[index],index,5'b0}, pmem_wdata=data[index]. On pmem_resp: dirty[index]=0, go to FILL.
  - FILL: pmem_read=1, pmem_address={req tag,index,5'b0}. On pmem_resp: data[index]=pmem_rdata, tag updated, valid=1, dirty=0, go to IDLE. The next cycle hits and responds.
- Miss latency: 1 (detect) + writeback burst (if dirty) + fill burst + 1 (hit) cycles. data_resp is never asserted in WRITEBACK or FILL.
- Pmem outputs are held stable from assertion until pmem_resp. pmem_read and pmem_write are never both 1.
- Dropped request: a request deasserted mid-miss does not abort the FSM. The burst completes and the line installs. No data_resp is issued without a request.
- data_read && data_write together is illegal. It is caught by a simulation assertion; write takes priority.
- Reset during WRITEBACK/FILL drops pmem_read/pmem_write immediately (async) and invalidates all lines. The pmem side must tolerate an abandoned burst.
- data_rdata=0 whenever data_resp=0 (eases waveform debug).
- Perf counters: hit_count and miss_count, 32-bit, internal only, reset to 0. Each increments once per completed request, classified by its first-cycle hit/miss.

Decomposition:
- Shared package cache_types:
  - cache_state_t enum {IDLE, WRITEBACK, FILL}
  - line_t (logic [255:0])
  - localparam LINE_WORDS = 8
- One sub-module, dcache_array: parameterized width/depth, async read, per-32-bit-word write enables plus full-line write. It is instantiated for data; tag/valid/dirty are plain register vectors in l1_dcache.
- FSM and hit logic stay in l1_dcache.

Test Plan:
- Cold read: rst, then data_read addr 0x0000_0040 → pmem_read with pmem_address 0x0000_0040. Return pmem_rdata word2=0xDEADBEEF, read addr 0x48 → data_resp same cycle with 0xDEADBEEF.
- Write hit byte merge: line at 0x40 resident, data_write addr 0x44, mbe=0010, wdata=0x0000_AB00. Then read 0x44 → old word with byte1=0xAB; dirty[2]=1.
- Dirty eviction: after the previous case, read 0x0000_0140 (same index 2, new tag) → pmem_write at 0x40 carrying the modified line, then pmem_read at 0x140, then resp.
- Reset mid-fill: assert rst during FILL → pmem_read falls without a clock edge. Re-read 0x40 → misses again.
- mbe=0000 store to resident clean line → data_resp=1, dirty stays 0. A later conflicting miss issues no pmem_write.
- Back-to-back hits: read 0x40, 0x44, 0x48 on consecutive cycles → data_resp=1 every cycle, no pmem activity, hit_count=3.

Source files
------------

// File: rtl/l1_dcache_pkg.sv
// rtl/l1_dcache_pkg.sv - shared cache types, line geometry and byte-merge helper
package cache_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } cache_state_t;

    typedef logic [255:0] line_t;

    localparam int LINE_WORDS = 8;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mbe);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mbe[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// rtl/l1_dcache_if.sv - CPU data port plus pmem line-burst port of the L1 data cache
interface l1_dcache_if;
    import cache_types::*;

    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    line_t       pmem_wdata;
    line_t       pmem_rdata;
    logic        pmem_resp;

    // Cache side: responder to the CPU, requester towards pmem.
    modport slave (
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        output data_resp, data_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        input  data_resp, data_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/l1_dcache_array.sv
// rtl/l1_dcache_array.sv - line storage with async read, per-word and full-line writes
module dcache_array #(
    parameter  int WIDTH = 256,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int WORDS = WIDTH / 32
) (
    input  logic             clk,
    input  logic [AW-1:0]    index,
    input  logic [WORDS-1:0] word_we,
    input  logic [31:0]      word_wdata,
    input  logic             line_we,
    input  logic [WIDTH-1:0] line_wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A fill replaces the whole line; otherwise individual words may be updated.
    always_ff @(posedge clk) begin
        if (line_we) begin
            mem[index] <= line_wdata;
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (word_we[w]) mem[index][w*32 +: 32] <= word_wdata;
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - direct-mapped write-back write-allocate L1 data cache
module l1_dcache
    import cache_types::*;
#(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input logic        clk,
    input logic        rst,
    l1_dcache_if.slave bus
);

    localparam int S_TAG  = 32 - S_INDEX - S_OFFSET;
    localparam int SETS   = 2 ** S_INDEX;
    localparam int S_LINE = 32 - S_OFFSET;

    cache_state_t state, state_next;

    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;
    logic [S_TAG-1:0]  tags [SETS];
    logic [S_LINE-1:0] miss_line;
    logic              miss_pending;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    logic                  req;
    logic                  is_write;
    logic                  hit;
    logic [S_TAG-1:0]      req_tag;
    logic [S_INDEX-1:0]    req_index;
    logic [S_INDEX-1:0]    miss_index;
    logic [S_INDEX-1:0]    arr_index;
    logic [2:0]            req_word;
    line_t                 cur_line;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;
    logic [LINE_WORDS-1:0] word_we;
    logic                  line_we;
    logic                  set_dirty;
    logic                  start_miss;
    logic                  unused_addr_bits;

    assign req_tag    = bus.data_addr[31 -: S_TAG];
    assign req_index  = bus.data_addr[S_OFFSET +: S_INDEX];
    assign req_word   = bus.data_addr[4:2];
    assign miss_index = miss_line[S_INDEX-1:0];
    assign unused_addr_bits = ^bus.data_addr[1:0];

    assign req      = bus.data_read | bus.data_write;
    assign is_write = bus.data_write;
    assign hit      = req && valid[req_index] && (tags[req_index] == req_tag);

    // While a miss is outstanding the array is steered by the latched miss line,
    // so a dropped or changed request cannot disturb the burst.
    assign arr_index   = (state == IDLE) ? req_index : miss_index;
    assign cur_word    = cur_line[req_word*32 +: 32];
    assign merged_word = merge_bytes(cur_word, bus.data_wdata, bus.data_mbe);

    dcache_array #(
        .WIDTH (256),
        .DEPTH (SETS)
    ) data_array (
        .clk        (clk),
        .index      (arr_index),
        .word_we    (word_we),
        .word_wdata (merged_word),
        .line_we    (line_we),
        .line_wdata (bus.pmem_rdata),
        .rdata      (cur_line)
    );

    assign bus.pmem_wdata = (state == WRITEBACK) ? cur_line : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next       = state;
        bus.data_resp    = 1'b0;
        bus.data_rdata   = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        word_we          = '0;
        line_we          = 1'b0;
        set_dirty        = 1'b0;
        start_miss       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        bus.data_resp = 1'b1;
                        if (is_write) begin
                            if (bus.data_mbe != 4'b0000) begin
                                word_we   = LINE_WORDS'(1) << req_word;
                                set_dirty = 1'b1;
                            end
                        end else begin
                            bus.data_rdata = cur_word;
                        end
                    end else begin
                        start_miss = 1'b1;
                        state_next = dirty[req_index] ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tags[miss_index], miss_index, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp) state_next = FILL;
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {miss_line, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp) begin
                    line_we    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters classify a request by its first cycle: a request that missed is
    // counted as a miss when its eventual hit response is delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid        <= '0;
            dirty        <= '0;
            miss_line    <= '0;
            miss_pending <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            if (start_miss) begin
                miss_line    <= bus.data_addr[31:S_OFFSET];
                miss_pending <= 1'b1;
            end
            if (set_dirty) dirty[req_index] <= 1'b1;
            if (state == WRITEBACK && bus.pmem_resp) dirty[miss_index] <= 1'b0;
            if (line_we) begin
                valid[miss_index] <= 1'b1;
                dirty[miss_index] <= 1'b0;
            end
            if (bus.data_resp) begin
                if (miss_pending) begin
                    miss_count   <= miss_count + 32'd1;
                    miss_pending <= 1'b0;
                end else begin
                    hit_count <= hit_count + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) tags[miss_index] <= miss_line[S_LINE-1 -: S_TAG];
    end

    a_no_read_write: assert property (@(posedge clk) disable iff (rst)
        !(bus.data_read && bus.data_write));

endmodule
